// File: rtl/conv_1.sv
// conv_1: first LeNet convolution layer, two 5x5 channels over a 28x28 image.
// One multiply-accumulate per cycle; each output pixel takes 25 MAC cycles and
// one WRITE cycle. The feature map is a register array that the pooling stage
// reads directly once done has pulsed.
//
// Control handshake:
//   start - single-cycle request, acted on only in IDLE (ignored in MAC,
//           WRITE and DONE). The edge that samples it enters MAC.
//   busy  - high in MAC and WRITE; image/weights/bias must be held stable
//           while it is high.
//   done  - high for exactly the one DONE cycle after the last WRITE; the
//           feature map is complete from that cycle until the next start.
module conv_1 #(
  parameter int bitwidth = 16,
  parameter int FRAC     = 8,
  parameter int RELU     = 1
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          start,
  input  logic signed [27:0][27:0][bitwidth-1:0]        image,
  input  logic signed [1:0][4:0][4:0][bitwidth-1:0]     weights,
  input  logic signed [1:0][bitwidth-1:0]               bias,
  output logic signed [1:0][27:0][27:0][bitwidth-1:0]   featuremap,
  output logic                                          busy,
  output logic                                          done,
  output logic [1:0]                                    dbg_state
);

  localparam int PW = 2 * bitwidth;
  localparam int AW = 2 * bitwidth + 5;

  // Saturation bounds expressed at accumulator width.
  localparam logic signed [AW-1:0] SAT_MAX = AW'(2 ** (bitwidth - 1) - 1);
  localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [4:0]               tap_q, tap_d;
  logic                     k_q, k_d;
  logic [4:0]               r_q, r_d;
  logic [4:0]               c_q, c_d;
  logic signed [AW-1:0]     acc_q, acc_d;
  logic [1:0][27:0][27:0][bitwidth-1:0] fm_q, fm_d;

  // Datapath intermediates.
  logic [2:0]               u, v;
  logic signed [6:0]        row_i, col_i;
  logic                     px_valid;
  logic signed [bitwidth-1:0] px, w_sel, b_sel;
  logic signed [PW-1:0]     prod;
  logic signed [AW-1:0]     prod_ext, bias_ext, sum, s_shift;
  logic [bitwidth-1:0]      res;

  // Kernel tap decode, zero-padded pixel fetch and the product for this tap.
  always_comb begin
    u        = 3'(tap_q / 5'd5);
    v        = 3'(tap_q % 5'd5);
    row_i    = $signed({2'b00, r_q}) + $signed({4'b0000, u}) - 7'sd2;
    col_i    = $signed({2'b00, c_q}) + $signed({4'b0000, v}) - 7'sd2;
    px_valid = !row_i[6] && (row_i <= 7'sd27) && !col_i[6] && (col_i <= 7'sd27);
    px       = '0;
    if (px_valid) begin
      px = image[row_i[4:0]][col_i[4:0]];
    end
    w_sel    = weights[k_q][u][v];
    prod     = w_sel * px;
    prod_ext = {{(AW - PW){prod[PW-1]}}, prod};
  end

  // Bias add, arithmetic rescale (floor), optional ReLU, then saturation.
  always_comb begin
    b_sel    = bias[k_q];
    bias_ext = {{(AW - bitwidth){b_sel[bitwidth-1]}}, b_sel} <<< FRAC;
    sum      = acc_q + bias_ext;
    s_shift  = sum >>> FRAC;
    if ((RELU != 0) && s_shift[AW-1]) begin
      res = '0;
    end else if (s_shift > SAT_MAX) begin
      res = SAT_MAX[bitwidth-1:0];
    end else if (s_shift < SAT_MIN) begin
      res = SAT_MIN[bitwidth-1:0];
    end else begin
      res = s_shift[bitwidth-1:0];
    end
  end

  // Next-state logic: frame sequencing, accumulation and feature-map writes.
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    k_d     = k_q;
    r_d     = r_q;
    c_d     = c_q;
    acc_d   = acc_q;
    fm_d    = fm_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_MAC;
          tap_d   = '0;
          k_d     = 1'b0;
          r_d     = '0;
          c_d     = '0;
          acc_d   = '0;
        end
      end
      S_MAC: begin
        acc_d = acc_q + prod_ext;
        tap_d = tap_q + 5'd1;
        if (tap_q == 5'd24) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        fm_d[k_q][r_q][c_q] = res;
        acc_d   = '0;
        tap_d   = '0;
        state_d = S_MAC;
        // Column innermost, then row, then channel.
        if (c_q == 5'd27) begin
          c_d = '0;
          if (r_q == 5'd27) begin
            r_d = '0;
            if (k_q) begin
              k_d     = 1'b0;
              state_d = S_DONE;
            end else begin
              k_d = 1'b1;
            end
          end else begin
            r_d = r_q + 5'd1;
          end
        end else begin
          c_d = c_q + 5'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tap_q   <= '0;
      k_q     <= 1'b0;
      r_q     <= '0;
      c_q     <= '0;
      acc_q   <= '0;
      fm_q    <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      k_q     <= k_d;
      r_q     <= r_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      fm_q    <= fm_d;
    end
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    busy       = (state_q == S_MAC) || (state_q == S_WRITE);
    done       = (state_q == S_DONE);
    dbg_state  = state_q;
    featuremap = fm_q;
  end

endmodule

// File: tb/tb_conv_1.sv
// tb_conv_1: directed bench for conv_1. Seven instances run their frames
// concurrently so that every scenario fits in one frame time plus the
// mid-frame reset scenario.
module tb_conv_1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_all, rst_r;
  logic start_a, start_b, start_r;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_bad;
  int done_cnt_a;

  // ---------------- stimulus operands ----------------
  logic signed [27:0][27:0][15:0]     img_ramp, img_256, img_max;
  logic signed [1:0][4:0][4:0][15:0]  w_id, w_256, w_sat, w_zero;
  logic signed [1:0][15:0]            b_zero, b_mix;

  // ---------------- DUT outputs ----------------
  logic signed [1:0][27:0][27:0][15:0] fm_id, fm_pad, fm_s1, fm_s0, fm_b1, fm_b0, fm_r;
  logic busy_id, busy_pad, busy_s1, busy_s0, busy_b1, busy_b0, busy_r;
  logic done_id, done_pad, done_s1, done_s0, done_b1, done_b0, done_r;
  logic [1:0] st_id, st_pad, st_s1, st_s0, st_b1, st_b0, st_r;

  conv_1 #(.bitwidth(16), .FRAC(8), .RELU(1)) dut_id (
    .clk(clk), .rst_n(rst_all), .start(start_a), .image(img_ramp), .weights(w_id),
    .bias(b_zero), .featuremap(fm_id), .busy(busy_id), .done(done_id), .dbg_state(st_id));
  conv_1 #(.bitwidth(16), .FRAC(8), .RELU(1)) dut_pad (
    .clk(clk), .rst_n(rst_all), .start(start_b), .image(img_256), .weights(w_256),
    .bias(b_zero), .featuremap(fm_pad), .busy(busy_pad), .done(done_pad), .dbg_state(st_pad));
  conv_1 #(.bitwidth(16), .FRAC(8), .RELU(1)) dut_s1 (
    .clk(clk), .rst_n(rst_all), .start(start_b), .image(img_max), .weights(w_sat),
    .bias(b_zero), .featuremap(fm_s1), .busy(busy_s1), .done(done_s1), .dbg_state(st_s1));
  conv_1 #(.bitwidth(16), .FRAC(8), .RELU(0)) dut_s0 (
    .clk(clk), .rst_n(rst_all), .start(start_b), .image(img_max), .weights(w_sat),
    .bias(b_zero), .featuremap(fm_s0), .busy(busy_s0), .done(done_s0), .dbg_state(st_s0));
  conv_1 #(.bitwidth(16), .FRAC(8), .RELU(1)) dut_b1 (
    .clk(clk), .rst_n(rst_all), .start(start_b), .image(img_ramp), .weights(w_zero),
    .bias(b_mix), .featuremap(fm_b1), .busy(busy_b1), .done(done_b1), .dbg_state(st_b1));
  conv_1 #(.bitwidth(16), .FRAC(8), .RELU(0)) dut_b0 (
    .clk(clk), .rst_n(rst_all), .start(start_b), .image(img_ramp), .weights(w_zero),
    .bias(b_mix), .featuremap(fm_b0), .busy(busy_b0), .done(done_b0), .dbg_state(st_b0));
  conv_1 #(.bitwidth(16), .FRAC(8), .RELU(1)) dut_r (
    .clk(clk), .rst_n(rst_r), .start(start_r), .image(img_ramp), .weights(w_id),
    .bias(b_zero), .featuremap(fm_r), .busy(busy_r), .done(done_r), .dbg_state(st_r));

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    logic [6:0] busy_v, done_v;
    rst_all = 1'b0;
    rst_r   = 1'b0;
    start_a = 1'b1;   // reset must win over start
    start_b = 1'b1;
    start_r = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    start_r = 1'b0;
    rst_all = 1'b1;
    rst_r   = 1'b1;
    busy_v = {busy_id, busy_pad, busy_s1, busy_s0, busy_b1, busy_b0, busy_r};
    done_v = {done_id, done_pad, done_s1, done_s0, done_b1, done_b0, done_r};
    n_vec++;
    if (busy_v !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_busy: got %b expected %b", busy_v, 7'b0);
    end
    n_vec++;
    if (done_v !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_done: got %b expected %b", done_v, 7'b0);
    end
    n_vec++;
    if (st_id !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_state: got %0d expected 0", st_id);
    end
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 28; r++)
        for (int c = 0; c < 28; c++) begin
          n_vec++;
          if (fm_id[k][r][c] !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_fm[%0d][%0d][%0d]: got %0d expected 0", k, r, c, $signed(fm_id[k][r][c]));
          end
        end
  endtask

  task automatic test_reset_mid_frame();
    int done_seen;
    @(negedge clk);
    start_r = 1'b1;
    @(posedge clk);            // edge 0
    #1;
    start_r = 1'b0;
    for (int cyc = 1; cyc < 10000; cyc++) begin
      @(posedge clk);
      #1;
    end
    n_vec++;
    if (busy_r !== 1'b1) begin
      n_bad++;
      $display("FAIL midframe_busy_before: got %b expected 1", busy_r);
    end
    n_vec++;
    if (fm_r[0][5][5] !== 16'd145) begin
      n_bad++;
      $display("FAIL midframe_partial_fm: got %0d expected 145", $signed(fm_r[0][5][5]));
    end
    rst_r = 1'b0;
    @(posedge clk);            // edge 10000, reset sampled
    #1;
    rst_r = 1'b1;
    n_vec++;
    if (busy_r !== 1'b0) begin
      n_bad++;
      $display("FAIL midframe_busy_after: got %b expected 0", busy_r);
    end
    n_vec++;
    if (done_r !== 1'b0) begin
      n_bad++;
      $display("FAIL midframe_done_after: got %b expected 0", done_r);
    end
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 28; r++)
        for (int c = 0; c < 28; c++) begin
          n_vec++;
          if (fm_r[k][r][c] !== 16'h0000) begin
            n_bad++;
            $display("FAIL midframe_fm[%0d][%0d][%0d]: got %0d expected 0", k, r, c, $signed(fm_r[k][r][c]));
          end
        end
    done_seen = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk);
      #1;
      if (done_r === 1'b1) done_seen++;
    end
    n_vec++;
    if (done_seen != 0) begin
      n_bad++;
      $display("FAIL midframe_no_done: got %0d pulses expected 0", done_seen);
    end
  endtask

  task automatic test_frame_timing();
    int first_a, first_b, first_r, busy_drop;
    logic [15:0] fm_before, fm_after;
    logic busy_at_done;
    first_a = -1;
    first_b = -1;
    first_r = -1;
    busy_drop = 0;
    fm_before = 16'hxxxx;
    fm_after  = 16'hxxxx;
    busy_at_done = 1'bx;
    done_cnt_a = 0;
    @(negedge clk);
    start_a = 1'b1;
    start_b = 1'b1;
    start_r = 1'b1;
    @(posedge clk);            // edge 0
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    start_r = 1'b0;
    n_vec++;
    if (busy_id !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_edge0: got %b expected 1", busy_id);
    end
    for (int cyc = 1; cyc <= 40800; cyc++) begin
      @(posedge clk);
      #1;
      if (done_id === 1'b1) begin
        done_cnt_a++;
        if (first_a < 0) first_a = cyc;
      end
      if (done_pad === 1'b1 && first_b < 0) first_b = cyc;
      if (done_r === 1'b1 && first_r < 0) first_r = cyc;
      if (cyc < 40768 && busy_id !== 1'b1) busy_drop++;
      if (cyc == 51) fm_before = fm_id[0][0][1];
      if (cyc == 52) fm_after = fm_id[0][0][1];
      if (cyc == 40768) busy_at_done = busy_id;
      // Extra start pulses: one mid-frame, one in the DONE cycle.
      start_a = (cyc == 99) || (cyc == 40768);
    end
    start_a = 1'b0;
    n_vec++;
    if (first_a != 40768) begin
      n_bad++;
      $display("FAIL done_latency: got %0d expected 40768", first_a);
    end
    n_vec++;
    if (first_b != 40768) begin
      n_bad++;
      $display("FAIL done_latency_b: got %0d expected 40768", first_b);
    end
    n_vec++;
    if (first_r != 40768) begin
      n_bad++;
      $display("FAIL done_latency_restart: got %0d expected 40768", first_r);
    end
    n_vec++;
    if (busy_drop != 0) begin
      n_bad++;
      $display("FAIL busy_hold: got %0d low cycles expected 0", busy_drop);
    end
    n_vec++;
    if (busy_at_done !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_in_done: got %b expected 0", busy_at_done);
    end
    n_vec++;
    if (fm_before !== 16'd0) begin
      n_bad++;
      $display("FAIL fm_before_write: got %0d expected 0", fm_before);
    end
    n_vec++;
    if (fm_after !== 16'd1) begin
      n_bad++;
      $display("FAIL fm_at_edge52: got %0d expected 1", fm_after);
    end
  endtask

  task automatic test_identity();
    logic [15:0] exp_v;
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 28; r++)
        for (int c = 0; c < 28; c++) begin
          exp_v = 16'(r * 28 + c);
          n_vec++;
          if (fm_id[k][r][c] !== exp_v) begin
            n_bad++;
            $display("FAIL identity[%0d][%0d][%0d]: got %0d expected %0d", k, r, c, $signed(fm_id[k][r][c]), exp_v);
          end
          n_vec++;
          if (fm_r[k][r][c] !== exp_v) begin
            n_bad++;
            $display("FAIL restart_identity[%0d][%0d][%0d]: got %0d expected %0d", k, r, c, $signed(fm_r[k][r][c]), exp_v);
          end
        end
  endtask

  task automatic test_padding();
    // {k, r, c, in-bounds tap count}
    int vec [6][4];
    logic [15:0] exp_v;
    vec = '{'{0, 0, 0, 9}, '{0, 0, 2, 15}, '{0, 14, 14, 25},
            '{1, 27, 27, 9}, '{1, 0, 13, 15}, '{0, 1, 1, 16}};
    for (int i = 0; i < 6; i++) begin
      exp_v = 16'(vec[i][3] * 256);
      n_vec++;
      if (fm_pad[vec[i][0]][vec[i][1]][vec[i][2]] !== exp_v) begin
        n_bad++;
        $display("FAIL padding[%0d][%0d][%0d]: got %0d expected %0d", vec[i][0], vec[i][1], vec[i][2],
                 $signed(fm_pad[vec[i][0]][vec[i][1]][vec[i][2]]), exp_v);
      end
    end
  endtask

  task automatic test_saturation_relu();
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++) begin
        n_vec++;
        if (fm_s1[0][r][c] !== 16'h7fff) begin
          n_bad++;
          $display("FAIL sat_pos_relu1[%0d][%0d]: got %0d expected 32767", r, c, $signed(fm_s1[0][r][c]));
        end
        n_vec++;
        if (fm_s0[0][r][c] !== 16'h7fff) begin
          n_bad++;
          $display("FAIL sat_pos_relu0[%0d][%0d]: got %0d expected 32767", r, c, $signed(fm_s0[0][r][c]));
        end
        n_vec++;
        if (fm_s1[1][r][c] !== 16'h0000) begin
          n_bad++;
          $display("FAIL relu_neg[%0d][%0d]: got %0d expected 0", r, c, $signed(fm_s1[1][r][c]));
        end
        n_vec++;
        if (fm_s0[1][r][c] !== 16'h8000) begin
          n_bad++;
          $display("FAIL sat_neg[%0d][%0d]: got %0d expected -32768", r, c, $signed(fm_s0[1][r][c]));
        end
      end
  endtask

  task automatic test_bias();
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++) begin
        n_vec++;
        if (fm_b1[0][r][c] !== 16'h0000) begin
          n_bad++;
          $display("FAIL bias_neg_relu1[%0d][%0d]: got %0d expected 0", r, c, $signed(fm_b1[0][r][c]));
        end
        n_vec++;
        if (fm_b0[0][r][c] !== 16'hffff) begin
          n_bad++;
          $display("FAIL bias_neg_relu0[%0d][%0d]: got %0d expected -1", r, c, $signed(fm_b0[0][r][c]));
        end
        n_vec++;
        if (fm_b1[1][r][c] !== 16'd5) begin
          n_bad++;
          $display("FAIL bias_pos_relu1[%0d][%0d]: got %0d expected 5", r, c, $signed(fm_b1[1][r][c]));
        end
        n_vec++;
        if (fm_b0[1][r][c] !== 16'd5) begin
          n_bad++;
          $display("FAIL bias_pos_relu0[%0d][%0d]: got %0d expected 5", r, c, $signed(fm_b0[1][r][c]));
        end
      end
  endtask

  task automatic test_start_while_busy();
    int busy_hi;
    n_vec++;
    if (done_cnt_a != 1) begin
      n_bad++;
      $display("FAIL done_once: got %0d pulses expected 1", done_cnt_a);
    end
    busy_hi = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk);
      #1;
      if (busy_id !== 1'b0 || done_id !== 1'b0) busy_hi++;
    end
    n_vec++;
    if (busy_hi != 0) begin
      n_bad++;
      $display("FAIL idle_after_done: got %0d active cycles expected 0", busy_hi);
    end
    n_vec++;
    if (st_id !== 2'd0) begin
      n_bad++;
      $display("FAIL state_after_done: got %0d expected 0", st_id);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_vec = 0;
    n_bad = 0;
    done_cnt_a = 0;
    rst_all = 1'b0;
    rst_r   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    start_r = 1'b0;
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++) begin
        img_ramp[r][c] = 16'(r * 28 + c);
        img_256[r][c]  = 16'sd256;
        img_max[r][c]  = 16'sd32767;
      end
    for (int k = 0; k < 2; k++) begin
      for (int u = 0; u < 5; u++)
        for (int v = 0; v < 5; v++) begin
          w_id[k][u][v]   = (u == 2 && v == 2) ? 16'sd256 : 16'sd0;
          w_256[k][u][v]  = 16'sd256;
          w_sat[k][u][v]  = (k == 0) ? 16'sd32767 : -16'sd32767;
          w_zero[k][u][v] = 16'sd0;
        end
      b_zero[k] = 16'sd0;
    end
    b_mix[0] = -16'sd1;
    b_mix[1] = 16'sd5;

    test_reset();
    test_reset_mid_frame();
    test_frame_timing();
    test_identity();
    test_padding();
    test_saturation_relu();
    test_bias();
    test_start_while_busy();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
